// File: rtl/network_rx_hcp.sv
// GMII receive framer for the HCP port: strips preamble/SFD and emits
// 9-bit packet words with first/last markers, error flags and counters.
module network_rx_hcp #(
   parameter int MIN_LEN = 64,
   parameter int MAX_LEN = 1522
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [7:0]  iv_gmii_rxd,
   input  logic        i_gmii_rx_dv,
   input  logic        i_gmii_rx_er,
   output logic [8:0]  ov_pkt_data,
   output logic        o_pkt_data_wr,
   output logic        o_pkt_err,
   output logic [15:0] ov_rx_pkt_cnt,
   output logic [15:0] ov_rx_err_cnt,
   output logic [1:0]  ov_rx_state
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRE     = 2'd1,
      DATA    = 2'd2,
      DISCARD = 2'd3
   } state_t;

   localparam logic [10:0] MIN_L = 11'(MIN_LEN);
   localparam logic [10:0] MAX_L = 11'(MAX_LEN);
   localparam logic [7:0]  PRE_B = 8'h55;
   localparam logic [7:0]  SFD_B = 8'hD5;

   state_t      state;
   logic [7:0]  hold;
   logic        held;
   logic        first;
   logic [10:0] len;
   logic        er_lat;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign ov_rx_state = state;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state         <= IDLE;
         hold          <= 8'd0;
         held          <= 1'b0;
         first         <= 1'b0;
         len           <= 11'd0;
         er_lat        <= 1'b0;
         ov_pkt_data   <= 9'd0;
         o_pkt_data_wr <= 1'b0;
         o_pkt_err     <= 1'b0;
         ov_rx_pkt_cnt <= 16'd0;
         ov_rx_err_cnt <= 16'd0;
      end else begin
         o_pkt_data_wr <= 1'b0;
         o_pkt_err     <= 1'b0;
         unique case (state)
            IDLE, PRE: begin
               if (!i_gmii_rx_dv) begin
                  state <= IDLE;
               end else if (iv_gmii_rxd == PRE_B) begin
                  state <= PRE;
               end else if (iv_gmii_rxd == SFD_B) begin
                  state  <= DATA;
                  len    <= 11'd0;
                  held   <= 1'b0;
                  first  <= 1'b1;
                  er_lat <= 1'b0;
               end else begin
                  state         <= DISCARD;
                  ov_rx_err_cnt <= sat_inc(ov_rx_err_cnt);
               end
            end
            DATA: begin
               if (!i_gmii_rx_dv) begin
                  state <= IDLE;
                  held  <= 1'b0;
                  if (held) begin
                     ov_pkt_data   <= {1'b1, hold};
                     o_pkt_data_wr <= 1'b1;
                     if (er_lat || len < MIN_L) begin
                        o_pkt_err     <= 1'b1;
                        ov_rx_err_cnt <= sat_inc(ov_rx_err_cnt);
                     end else begin
                        ov_rx_pkt_cnt <= sat_inc(ov_rx_pkt_cnt);
                     end
                  end else begin
                     // SFD followed directly by end of carrier: empty frame
                     ov_rx_err_cnt <= sat_inc(ov_rx_err_cnt);
                  end
               end else if (len == MAX_L) begin
                  state         <= DISCARD;
                  held          <= 1'b0;
                  ov_pkt_data   <= {1'b1, hold};
                  o_pkt_data_wr <= 1'b1;
                  o_pkt_err     <= 1'b1;
                  ov_rx_err_cnt <= sat_inc(ov_rx_err_cnt);
               end else begin
                  len  <= len + 11'd1;
                  hold <= iv_gmii_rxd;
                  held <= 1'b1;
                  if (i_gmii_rx_er) er_lat <= 1'b1;
                  if (held) begin
                     ov_pkt_data   <= {first, hold};
                     o_pkt_data_wr <= 1'b1;
                     first         <= 1'b0;
                  end
               end
            end
            DISCARD: begin
               if (!i_gmii_rx_dv) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_network_rx_hcp.sv
// Directed bench for network_rx_hcp: framing, errors, over-length,
// back-to-back frames, reset mid-frame and counter saturation.
module tb_network_rx_hcp;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  rxd;
   logic        dv;
   logic        er;
   logic [8:0]  pkt_data;
   logic        pkt_wr;
   logic        pkt_err;
   logic [15:0] pkt_cnt;
   logic [15:0] err_cnt;
   logic [1:0]  state;

   int n_cmp = 0;
   int n_bad = 0;

   logic [8:0] wq[$];
   bit         eq[$];
   int         err_pulses = 0;

   always #4 clk = ~clk;

   network_rx_hcp #(.MIN_LEN(64), .MAX_LEN(1522)) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .iv_gmii_rxd   (rxd),
      .i_gmii_rx_dv  (dv),
      .i_gmii_rx_er  (er),
      .ov_pkt_data   (pkt_data),
      .o_pkt_data_wr (pkt_wr),
      .o_pkt_err     (pkt_err),
      .ov_rx_pkt_cnt (pkt_cnt),
      .ov_rx_err_cnt (err_cnt),
      .ov_rx_state   (state)
   );

   always @(negedge clk) begin
      if (pkt_wr) begin
         wq.push_back(pkt_data);
         eq.push_back(pkt_err);
      end
      if (pkt_err) err_pulses++;
   end

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [7:0] d, input logic v, input logic e);
      @(negedge clk);
      rxd = d;
      dv  = v;
      er  = e;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(8'h00, 1'b0, 1'b0);
   endtask

   task automatic send(input int n, input int er_at, input int gap);
      for (int i = 0; i < 7; i++) drive(8'h55, 1'b1, 1'b0);
      drive(8'hD5, 1'b1, 1'b0);
      for (int i = 1; i <= n; i++) drive(8'(i - 1), 1'b1, i == er_at);
      for (int i = 0; i < gap; i++) drive(8'h00, 1'b0, 1'b0);
   endtask

   task automatic clr();
      wq.delete();
      eq.delete();
      err_pulses = 0;
   endtask

   function automatic int marks();
      int m = 0;
      foreach (wq[i]) if (wq[i][8]) m++;
      return m;
   endfunction

   initial begin
      rst = 1'b1;
      rxd = 8'h00;
      dv  = 1'b0;
      er  = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_data", int'(pkt_data), 0);
      chk("rst_wr", int'(pkt_wr), 0);
      chk("rst_cnts", int'({pkt_cnt, err_cnt}), 0);
      chk("rst_state", int'(state), 0);
      rst = 1'b0;
      idle(2);

      // good 64-byte frame
      clr();
      send(64, 0, 1);
      idle(3);
      chk("good_words", wq.size(), 64);
      chk("good_first", int'(wq[0]), 'h100);
      chk("good_last", int'(wq[63]), 'h13F);
      chk("good_marks", marks(), 2);
      chk("good_w10", int'(wq[10]), 'h00A);
      chk("good_err", err_pulses, 0);
      chk("good_pkt", int'(pkt_cnt), 1);
      chk("good_errcnt", int'(err_cnt), 0);

      // rx_er on byte 10
      clr();
      send(64, 10, 1);
      idle(3);
      chk("er_words", wq.size(), 64);
      chk("er_lastflag", int'(eq[63]), 1);
      chk("er_pulses", err_pulses, 1);
      chk("er_errcnt", int'(err_cnt), 1);
      chk("er_pkt", int'(pkt_cnt), 1);

      // runt
      clr();
      send(20, 0, 1);
      idle(3);
      chk("runt_words", wq.size(), 20);
      chk("runt_first", int'(wq[0]), 'h100);
      chk("runt_last", int'(wq[19]), 'h113);
      chk("runt_lastflag", int'(eq[19]), 1);
      chk("runt_errcnt", int'(err_cnt), 2);

      // over-length: dv left high after 1600 bytes
      clr();
      send(1600, 0, 0);
      chk("ovl_words", wq.size(), 1522);
      chk("ovl_last", int'(wq[1521]), 'h1F1);
      chk("ovl_lastflag", int'(eq[1521]), 1);
      chk("ovl_pulses", err_pulses, 1);
      chk("ovl_marks", marks(), 2);
      chk("ovl_state", int'(state), 3);
      chk("ovl_errcnt", int'(err_cnt), 3);
      idle(2);
      chk("ovl_idle", int'(state), 0);

      // two frames, one idle cycle apart
      clr();
      send(64, 0, 1);
      send(64, 0, 1);
      idle(3);
      chk("b2b_words", wq.size(), 128);
      chk("b2b_marks", marks(), 4);
      chk("b2b_end1", int'(wq[63]), 'h13F);
      chk("b2b_start2", int'(wq[64]), 'h100);
      chk("b2b_pkt", int'(pkt_cnt), 3);

      // reset during word 30, release on a data byte
      clr();
      for (int i = 0; i < 7; i++) drive(8'h55, 1'b1, 1'b0);
      drive(8'hD5, 1'b1, 1'b0);
      for (int i = 0; i < 100 && wq.size() < 30; i++)
         drive(8'(i), 1'b1, 1'b0);
      chk("rstm_reached", wq.size(), 30);
      rst = 1'b1;
      rxd = 8'hA7;
      #1;
      chk("rstm_wr", int'(pkt_wr), 0);
      chk("rstm_data", int'(pkt_data), 0);
      chk("rstm_cnts", int'({pkt_cnt, err_cnt}), 0);
      @(negedge clk);
      rst = 1'b0;
      clr();
      repeat (5) @(negedge clk);
      chk("rstm_state", int'(state), 3);
      chk("rstm_nowords", wq.size(), 0);
      chk("rstm_errcnt", int'(err_cnt), 1);
      idle(2);
      chk("rstm_idle", int'(state), 0);

      // saturation of the good-frame counter
      @(negedge clk);
      force dut.ov_rx_pkt_cnt = 16'hFFFF;
      @(negedge clk);
      release dut.ov_rx_pkt_cnt;
      clr();
      send(64, 0, 1);
      idle(3);
      chk("sat_words", wq.size(), 64);
      chk("sat_pkt", int'(pkt_cnt), 'hFFFF);
      chk("sat_errcnt", int'(err_cnt), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
